// File: rtl/nvdla_intr_bridge_if.sv
// SNAP action interrupt request/acknowledge bundle.
// The bridge drives the request side; the SNAP shell drives the acknowledge.
interface nvdla_intr_bridge_if #(
  parameter int INT_BITS     = 3,
  parameter int CONTEXT_BITS = 8
);
  logic                    interrupt;
  logic [INT_BITS-2:0]     interrupt_src;
  logic [CONTEXT_BITS-1:0] interrupt_ctx;
  logic                    interrupt_ack;

  modport master (
    output interrupt,
    output interrupt_src,
    output interrupt_ctx,
    input  interrupt_ack
  );

  modport slave (
    input  interrupt,
    input  interrupt_src,
    input  interrupt_ctx,
    output interrupt_ack
  );
endinterface

// File: rtl/nvdla_intr_bridge.sv
// Turns the NVDLA level interrupt into one SNAP request per assertion.
// Post-ack holdoff, re-arm on a fresh assertion, saturating ack counter.
module nvdla_intr_bridge #(
  parameter int INT_BITS       = 3,
  parameter int CONTEXT_BITS   = 8,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    nvdla_intr,
  input  logic                    intr_enable,
  input  logic [INT_BITS-2:0]     intr_src_cfg,
  input  logic [CONTEXT_BITS-1:0] intr_ctx_cfg,
  nvdla_intr_bridge_if.master     snap,
  output logic                    intr_busy,
  output logic [CNT_WIDTH-1:0]    intr_count,
  input  logic                    cnt_clear
);

  localparam int HW =
    (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HLOAD = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLDOFF,
    WAIT_CLR
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    intr_q;
  logic                    seen_low_q;
  logic [HW-1:0]           hold_q;
  logic [INT_BITS-2:0]     src_q;
  logic [CONTEXT_BITS-1:0] ctx_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    irq;
  logic                    busy;
  logic                    ack_take;
  logic                    hold_done;
  logic                    enter_req;

  assign ack_take  = (state_q == REQ) && snap.interrupt_ack;
  assign hold_done = (hold_q == '0);
  assign enter_req = (state_d == REQ) && (state_q != REQ);

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decision, all based on the registered interrupt.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (intr_q && intr_enable) state_d = REQ;
      end
      REQ: begin
        if (snap.interrupt_ack) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_done) begin
          if (!intr_q) begin
            state_d = IDLE;
          end else if (seen_low_q && intr_enable) begin
            state_d = REQ;
          end else begin
            state_d = WAIT_CLR;
          end
        end
      end
      WAIT_CLR: begin
        if (!intr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request and busy flags decoded from the state register only.
  always_comb begin
    irq  = 1'b0;
    busy = 1'b1;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      REQ:     irq  = 1'b1;
      default: ;
    endcase
  end

  // Input sync stage, holdoff timer and fresh-assertion tracking.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      intr_q     <= 1'b0;
      hold_q     <= '0;
      seen_low_q <= 1'b0;
    end else begin
      intr_q <= nvdla_intr;
      if (ack_take) begin
        hold_q     <= HLOAD;
        seen_low_q <= 1'b0;
      end else if (state_q == HOLDOFF) begin
        if (!hold_done) hold_q <= hold_q - 1'b1;
        if (!intr_q) seen_low_q <= 1'b1;
      end
    end
  end

  // Source/context captured when a request is issued.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      src_q <= '0;
      ctx_q <= '0;
    end else if (enter_req) begin
      src_q <= intr_src_cfg;
      ctx_q <= intr_ctx_cfg;
    end
  end

  // Saturating acknowledge counter; clear wins but keeps a same-cycle ack.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clear) begin
      cnt_q <= ack_take ? CNT_WIDTH'(1) : '0;
    end else if (ack_take && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign snap.interrupt     = irq;
  assign snap.interrupt_src = src_q;
  assign snap.interrupt_ctx = ctx_q;
  assign intr_busy          = busy;
  assign intr_count         = cnt_q;

endmodule
